gf_power_map_engine: RTL and testbench

//  Iterative power-map S-box engine: computes y = x^e over GF(2^N), field set by POLY, exponent e at run time.

---
 rtl/gf_power_map_engine.sv | 117 +++++++++++
 tb/tb_gf_power_map_engine.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_power_map_engine.sv
// Iterative power-map S-box: y = x^e over GF(2^N) by MSB-first square-and-multiply,
// one operation in flight, valid/ready handshakes on both sides, EW cycles per result.
module gf_power_map_engine #(
    parameter int unsigned N    = 6,
    parameter logic [N:0]  POLY = 7'b1000011,
    parameter int unsigned EW   = N
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  x_in,
    input  logic [EW-1:0] e_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  y_out,
    output logic          busy
);

    localparam int unsigned IW = (EW > 1) ? $clog2(EW) : 1;

    if (!POLY[N]) begin : g_bad_poly
        $error("gf_power_map_engine: POLY bit N must be set");
    end
    if (N < 3 || N > 16) begin : g_bad_width
        $error("gf_power_map_engine: N must be in 3..16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    acc_q, x_q;
    logic [EW-1:0]   e_q;
    logic [IW-1:0]   idx_q;
    logic            accept, finish, release_out;
    logic [N-1:0]    acc_sq, mul_op, acc_next;

    // Shift-and-add multiply with the reduction folded into each shift step.
    function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] p;
        logic [N-1:0] s;
        p = '0;
        s = a;
        for (int unsigned i = 0; i < N; i++) begin
            if (b[i]) p = p ^ s;
            s = s[N-1] ? ((s << 1) ^ POLY[N-1:0]) : (s << 1);
        end
        return p;
    endfunction

    assign acc_sq   = gf_mul(acc_q, acc_q);
    assign mul_op   = e_q[idx_q] ? x_q : N'(1);
    assign acc_next = gf_mul(acc_sq, mul_op);

    // Next-state and step decode.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        finish      = 1'b0;
        release_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == '0) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            y_out     <= '0;
            acc_q     <= '0;
            x_q       <= '0;
            e_q       <= '0;
            idx_q     <= '0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d == IDLE);
            busy     <= (state_d != IDLE);
            if (accept) begin
                x_q   <= x_in;
                e_q   <= e_in;
                acc_q <= N'(1);
                idx_q <= IW'(EW - 1);
            end else if (state_q == RUN) begin
                acc_q <= acc_next;
                if (idx_q != '0) idx_q <= idx_q - IW'(1);
            end
            if (finish) begin
                y_out     <= acc_next;
                out_valid <= 1'b1;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gf_power_map_engine.sv
// Bench for gf_power_map_engine: directed GF(2^6) cases plus random N=4 / N=8 runs
// against a carry-less-multiply-then-divide power model.
module tb_gf_power_map_engine;

    logic        clk;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  busy;
    logic [15:0] x_bus;
    logic [15:0] e_bus;
    logic [5:0]  y6;
    logic [3:0]  y4;
    logic [7:0]  y8;

    int checks = 0;
    int errors = 0;

    gf_power_map_engine #(.N(6), .POLY(7'b1000011), .EW(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x_in(x_bus[5:0]), .e_in(e_bus[5:0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .y_out(y6), .busy(busy[0]));

    gf_power_map_engine #(.N(4), .POLY(5'b10011), .EW(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x_in(x_bus[3:0]), .e_in(e_bus[3:0]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .y_out(y4), .busy(busy[1]));

    gf_power_map_engine #(.N(8), .POLY(9'h11B), .EW(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .x_in(x_bus[7:0]), .e_in(e_bus[7:0]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .y_out(y8), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: full carry-less product, then polynomial long division.
    function automatic int ref_mul(input int a, input int b, input int n, input int poly);
        int p;
        p = 0;
        for (int i = 0; i < n; i++)
            if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int i = 2 * n - 2; i >= n; i--)
            if (((p >> i) & 1) != 0) p = p ^ (poly << (i - n));
        return p;
    endfunction

    function automatic int ref_pow(input int x, input int e, input int n, input int poly);
        int r;
        r = 1;
        for (int k = 0; k < e; k++) r = ref_mul(r, x, n, poly);
        return r;
    endfunction

    function automatic int get_y(input int sel);
        case (sel)
            0:       return int'(y6);
            1:       return int'(y4);
            default: return int'(y8);
        endcase
    endfunction

    task automatic run_op(input int sel, input int x, input int e, output int y, output int lat);
        int guard;
        guard = 0;
        while (!in_ready[sel] && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        @(negedge clk);
        x_bus = 16'(x);
        e_bus = 16'(e);
        in_valid[sel] = 1'b1;
        @(posedge clk); #1;
        in_valid[sel] = 1'b0;
        lat = 0;
        while (!out_valid[sel] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        y = get_y(sel);
        if (!out_valid[sel]) begin
            checks++;
            errors++;
            $display("FAIL op_timeout sel=%0d x=%0h e=%0d: out_valid never rose", sel, x, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 3'b111;
        x_bus     = '0;
        e_bus     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy, out_valid} !== {3'b111, 3'b000, 3'b000}) begin
            errors++;
            $display("FAIL reset_flags got in_ready=%b busy=%b out_valid=%b want 111 000 000",
                     in_ready, busy, out_valid);
        end
        checks++;
        if ({y6, y4, y8} !== 18'h0) begin
            errors++;
            $display("FAIL reset_y got y6=%h y4=%h y8=%h want 0", y6, y4, y8);
        end
    endtask

    task automatic test_basic();
        int y, lat;
        run_op(0, 'h02, 38, y, lat);
        checks++;
        if (y !== 'h1B) begin
            errors++;
            $display("FAIL basic_x38 got %h want 1b", y);
        end
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL basic_latency got %0d want 6", lat);
        end
    endtask

    task automatic test_inverse();
        int y, lat;
        run_op(0, 'h02, 62, y, lat);
        checks++;
        if (y !== 'h21) begin
            errors++;
            $display("FAIL inverse_x62 got %h want 21", y);
        end
        run_op(0, 'h21, 1, y, lat);
        checks++;
        if (y !== 'h21) begin
            errors++;
            $display("FAIL identity_e1 got %h want 21", y);
        end
    endtask

    task automatic test_edges();
        int xs[4] = '{'h00, 'h00, 'h01, 'h02};
        int es[4] = '{0, 5, 63, 63};
        int ws[4] = '{'h01, 'h00, 'h01, 'h01};
        int y, lat;
        for (int i = 0; i < 4; i++) begin
            run_op(0, xs[i], es[i], y, lat);
            checks++;
            if (y !== ws[i]) begin
                errors++;
                $display("FAIL edge_pow x=%h e=%0d got %h want %h", xs[i], es[i], y, ws[i]);
            end
        end
    endtask

    task automatic test_hold();
        int guard;
        out_ready[0] = 1'b0;
        @(negedge clk);
        x_bus = 16'h02;
        e_bus = 16'd38;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        x_bus = 16'h05;
        e_bus = 16'd1;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        guard = 0;
        while (!out_valid[0] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (y6 !== 6'h1B || !out_valid[0]) begin
            errors++;
            $display("FAIL hold_result got y=%h valid=%b want 1b 1", y6, out_valid[0]);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid[0], in_ready[0], busy[0], y6} !== {3'b101, 6'h1B}) begin
                errors++;
                $display("FAIL hold_stable cycle=%0d got valid=%b ready=%b busy=%b y=%h want 1 0 1 1b",
                         i, out_valid[0], in_ready[0], busy[0], y6);
            end
        end
        @(negedge clk);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid[0], busy[0], in_ready[0]} !== 3'b001) begin
            errors++;
            $display("FAIL hold_release got valid=%b busy=%b ready=%b want 0 0 1",
                     out_valid[0], busy[0], in_ready[0]);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ({out_valid[0], busy[0]} !== 2'b00) begin
            errors++;
            $display("FAIL no_queue got valid=%b busy=%b want 0 0", out_valid[0], busy[0]);
        end
    endtask

    task automatic test_reset_mid();
        int y, lat;
        @(negedge clk);
        x_bus = 16'h07;
        e_bus = 16'd45;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid[0], busy[0], in_ready[0], y6} !== {3'b001, 6'h00}) begin
            errors++;
            $display("FAIL reset_mid got valid=%b busy=%b ready=%b y=%h want 0 0 1 00",
                     out_valid[0], busy[0], in_ready[0], y6);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 'h02, 38, y, lat);
        checks++;
        if (y !== 'h1B || lat !== 6) begin
            errors++;
            $display("FAIL after_reset got y=%h lat=%0d want 1b 6", y, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        x_bus = 16'h02;
        e_bus = 16'd38;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        x_bus = 16'h21;
        e_bus = 16'd1;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            if (j == 6) begin
                checks++;
                if ({out_valid[0], y6} !== {1'b1, 6'h1B}) begin
                    errors++;
                    $display("FAIL b2b_first got valid=%b y=%h want 1 1b", out_valid[0], y6);
                end
            end
            if (j == 7) begin
                checks++;
                if ({out_valid[0], busy[0], in_ready[0]} !== 3'b001) begin
                    errors++;
                    $display("FAIL b2b_idle_gap got valid=%b busy=%b ready=%b want 0 0 1",
                             out_valid[0], busy[0], in_ready[0]);
                end
            end
            if (j == 8) begin
                checks++;
                if ({busy[0], in_ready[0]} !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_second_accept got busy=%b ready=%b want 1 0",
                             busy[0], in_ready[0]);
                end
            end
        end
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (y6 !== 6'h21 || lat !== 6) begin
            errors++;
            $display("FAIL b2b_second got y=%h lat=%0d want 21 6", y6, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int sel, input int n, input int poly, input int count);
        int x, e, y, lat, want;
        for (int i = 0; i < count; i++) begin
            x = int'($urandom_range(0, (1 << n) - 1));
            e = int'($urandom_range(0, (1 << n) - 1));
            want = ref_pow(x, e, n, poly);
            run_op(sel, x, e, y, lat);
            checks++;
            if (y !== want || lat !== n) begin
                errors++;
                $display("FAIL random_n%0d x=%h e=%0d got y=%h lat=%0d want y=%h lat=%0d",
                         n, x, e, y, lat, want, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inverse();
        test_edges();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random(1, 4, 'h13, 2500);
        test_random(2, 8, 'h11B, 2500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
